irrigation_scheduler: RTL and testbench

Parametrised multi-zone successor to the single-bed irrigation controller. It round-robins over `N_ZONES` beds and decides sprinkler, drip or no watering from each bed's air-humidity, soil-humidity and temperature bits. It gates every decision on the tank level and times each watering run with a reloadable seconds countdown. It sits between the sensor inputs and the valve drivers and display decoders; the 1 Hz strobe comes from the existing frequency divider.

---
 rtl/irrigation_pkg.sv | 18 +
 rtl/irrigation_scheduler_sync_edge.sv | 29 ++
 rtl/irrigation_scheduler.sv | 176 +++++++++++++++++
 tb/tb_irrigation_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared encodings for the multi-zone irrigation scheduler: watering modes,
// tank-level thresholds and the scheduler FSM states.
package irrigation_pkg;

    localparam logic [1:0] MODE_NONE      = 2'b00;
    localparam logic [1:0] MODE_DRIP      = 2'b01;
    localparam logic [1:0] MODE_SPRINKLER = 2'b10;

    localparam logic [1:0] LEVEL_EMPTY = 2'd0;
    localparam logic [1:0] LEVEL_LOW   = 2'd1;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_WATER  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/irrigation_scheduler_sync_edge.sv
// Two-flop synchroniser for a raw asynchronous push input, followed by a
// rising-edge detector that yields a single-cycle pulse.
module sync_edge (
    input  logic clock_50MHz,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= sig;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // sync_p2 is the edge register: high for exactly one cycle after a 0->1
    assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/irrigation_scheduler.sv
// Round-robin multi-zone irrigation scheduler: picks sprinkler/drip/none per
// bed, gates on the tank level and times each run with a 1 Hz countdown.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int N_ZONES     = 4,
    parameter int SPRINKLER_S = 30,
    parameter int DRIP_S      = 20,
    parameter int PAUSE_S     = 2,
    parameter int ZW          = $clog2(N_ZONES),
    parameter int SW          = $clog2(((SPRINKLER_S > DRIP_S ? SPRINKLER_S : DRIP_S) > PAUSE_S
                                        ? (SPRINKLER_S > DRIP_S ? SPRINKLER_S : DRIP_S)
                                        : PAUSE_S) + 1)
) (
    input  logic               clock_50MHz,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic [N_ZONES-1:0] air_umidity,
    input  logic [N_ZONES-1:0] soil_umidity,
    input  logic [N_ZONES-1:0] temperature,
    input  logic [1:0]         water_level,
    input  logic               button,
    output logic [N_ZONES-1:0] valve,
    output logic [1:0]         mode,
    output logic [ZW-1:0]      active_zone,
    output logic [SW-1:0]      remaining,
    output logic               done,
    output logic               aborted
);

    localparam logic [SW-1:0] SPRINKLER_L = SW'(SPRINKLER_S);
    localparam logic [SW-1:0] DRIP_L      = SW'(DRIP_S);
    localparam logic [SW-1:0] PAUSE_L     = SW'(PAUSE_S);
    localparam logic [ZW-1:0] LAST_ZONE   = ZW'(N_ZONES - 1);

    // Need decision with low-tank demotion folded in.
    function automatic logic [1:0] need_mode(input logic air, input logic soil,
                                             input logic hot, input logic [1:0] level);
        if (soil || level == LEVEL_EMPTY)
            return MODE_NONE;
        else if (!air || hot)
            return (level == LEVEL_LOW) ? MODE_DRIP : MODE_SPRINKLER;
        else
            return MODE_DRIP;
    endfunction

    state_t             state;
    state_t             state_n;
    logic [ZW-1:0]      ptr;
    logic [ZW-1:0]      ptr_n;
    logic [ZW-1:0]      ptr_next;
    logic [N_ZONES-1:0] valve_n;
    logic [N_ZONES-1:0] zone_onehot;
    logic [1:0]         mode_n;
    logic [1:0]         mode_req;
    logic [SW-1:0]      remaining_n;
    logic               done_n;
    logic               aborted_n;
    logic               finish;
    logic               abort;
    logic               btn_rise;

    sync_edge u_button (
        .clock_50MHz (clock_50MHz),
        .reset       (reset),
        .sig         (button),
        .rise        (btn_rise)
    );

    assign ptr_next    = (ptr == LAST_ZONE) ? '0 : ptr + ZW'(1);
    assign mode_req    = need_mode(air_umidity[ptr], soil_umidity[ptr],
                                   temperature[ptr], water_level);
    assign active_zone = ptr;

    always_comb begin
        zone_onehot = '0;
        for (int i = 0; i < N_ZONES; i++)
            zone_onehot[i] = (ptr == ZW'(i));
    end

    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            state     <= ST_SCAN;
            ptr       <= '0;
            valve     <= '0;
            mode      <= MODE_NONE;
            remaining <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            valve     <= valve_n;
            mode      <= mode_n;
            remaining <= remaining_n;
            done      <= done_n;
            aborted   <= aborted_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        valve_n     = valve;
        mode_n      = mode;
        remaining_n = remaining;
        done_n      = 1'b0;
        aborted_n   = 1'b0;
        finish      = 1'b0;
        abort       = 1'b0;

        case (state)
            ST_SCAN: begin
                if (mode_req == MODE_NONE) begin
                    ptr_n = ptr_next;
                end else begin
                    state_n     = ST_WATER;
                    mode_n      = mode_req;
                    valve_n     = zone_onehot;
                    remaining_n = (mode_req == MODE_SPRINKLER) ? SPRINKLER_L : DRIP_L;
                end
            end

            ST_WATER: begin
                // Empty tank beats button beats tick beats demotion.
                if (water_level == LEVEL_EMPTY) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else if (btn_rise) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else if (tick_1hz) begin
                    if (remaining == SW'(1))
                        finish = 1'b1;
                    else
                        remaining_n = remaining - SW'(1);
                end else if (mode == MODE_SPRINKLER && water_level == LEVEL_LOW) begin
                    mode_n = MODE_DRIP;
                    if (remaining > DRIP_L)
                        remaining_n = DRIP_L;
                end

                if (finish) begin
                    done_n    = 1'b1;
                    aborted_n = abort;
                    valve_n   = '0;
                    mode_n    = MODE_NONE;
                    ptr_n     = ptr_next;
                    if (PAUSE_S > 0) begin
                        state_n     = ST_SETTLE;
                        remaining_n = PAUSE_L;
                    end else begin
                        state_n     = ST_SCAN;
                        remaining_n = '0;
                    end
                end
            end

            ST_SETTLE: begin
                if (tick_1hz) begin
                    if (remaining <= SW'(1)) begin
                        state_n     = ST_SCAN;
                        remaining_n = '0;
                    end else begin
                        remaining_n = remaining - SW'(1);
                    end
                end
            end

            default: begin
                state_n = ST_SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench: a default 4-zone scheduler plus a 3-zone, no-pause build
// driven from one initial block, one task per scenario.
module tb_irrigation_scheduler;

    logic clk = 1'b0;
    logic tick = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic       rst1 = 1'b1;
    logic [3:0] air1 = 4'hF, soil1 = 4'hF, temp1 = 4'h0;
    logic [1:0] level1 = 2'd3;
    logic       btn1 = 1'b0;
    logic [3:0] valve1;
    logic [1:0] mode1, zone1;
    logic [4:0] rem1;
    logic       done1, abort1;

    // N_ZONES=3, PAUSE_S=0 build
    logic       rst2 = 1'b1;
    logic [2:0] air2 = 3'h7, soil2 = 3'h7, temp2 = 3'h0;
    logic [1:0] level2 = 2'd3;
    logic       btn2 = 1'b0;
    logic [2:0] valve2;
    logic [1:0] mode2, zone2;
    logic [1:0] rem2;
    logic       done2, abort2;

    irrigation_scheduler dut1 (
        .clock_50MHz (clk), .reset (rst1), .tick_1hz (tick),
        .air_umidity (air1), .soil_umidity (soil1), .temperature (temp1),
        .water_level (level1), .button (btn1),
        .valve (valve1), .mode (mode1), .active_zone (zone1),
        .remaining (rem1), .done (done1), .aborted (abort1)
    );

    irrigation_scheduler #(.N_ZONES(3), .SPRINKLER_S(3), .DRIP_S(2), .PAUSE_S(0)) dut2 (
        .clock_50MHz (clk), .reset (rst2), .tick_1hz (tick),
        .air_umidity (air2), .soil_umidity (soil2), .temperature (temp2),
        .water_level (level2), .button (btn2),
        .valve (valve2), .mode (mode2), .active_zone (zone2),
        .remaining (rem2), .done (done2), .aborted (abort2)
    );

    logic [14:0] obs1;
    assign obs1 = {valve1, mode1, zone1, rem1, done1, abort1};

    logic [14:0] exp_q[$];
    int          zone_q[$];
    logic [14:0] want;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic logic [14:0] mk(logic [3:0] v, logic [1:0] m, logic [1:0] z,
                                       logic [4:0] r, logic d, logic a);
        return {v, m, z, r, d, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic wait_valve1();
        for (int i = 0; i < 20 && valve1 == 4'h0; i++) step();
    endtask

    task automatic test_reset();
        exp_q.push_back(mk(4'h0, 2'b00, 2'd0, 5'd0, 1'b0, 1'b0));
        step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL reset_state got %h want %h", obs1, want); end
    endtask

    task automatic test_sprinkler_run();
        soil1 = 4'b1011; air1 = 4'b1011; temp1 = 4'h0; level1 = 2'd3;
        exp_q.push_back(mk(4'b0100, 2'b10, 2'd2, 5'd30, 1'b0, 1'b0));
        exp_q.push_back(mk(4'b0100, 2'b10, 2'd2, 5'd1, 1'b0, 1'b0));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd3, 5'd2, 1'b1, 1'b0));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd3, 5'd2, 1'b0, 1'b0));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd3, 5'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd0, 5'd0, 1'b0, 1'b0));
        rst1 = 1'b0;
        step(); step(); step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL spr_open got %h want %h", obs1, want); end
        ticks(29);
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL spr_rem1 got %h want %h", obs1, want); end
        ticks(1);
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL spr_done got %h want %h", obs1, want); end
        step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL spr_settle got %h want %h", obs1, want); end
        ticks(2);
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL spr_resume got %h want %h", obs1, want); end
        soil1 = 4'hF;
        step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL spr_next_zone got %h want %h", obs1, want); end
    endtask

    task automatic test_drip_and_empty();
        soil1 = 4'b1101; air1 = 4'hF; temp1 = 4'h0; level1 = 2'd3;
        exp_q.push_back(mk(4'b0010, 2'b01, 2'd1, 5'd20, 1'b0, 1'b0));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd2, 5'd2, 1'b1, 1'b1));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd2, 5'd2, 1'b0, 1'b0));
        exp_q.push_back(mk(4'b0010, 2'b10, 2'd1, 5'd30, 1'b0, 1'b0));
        wait_valve1();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL drip_open got %h want %h", obs1, want); end
        level1 = 2'd0;
        step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL empty_abort got %h want %h", obs1, want); end
        level1 = 2'd3;
        step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL abort_pulse_len got %h want %h", obs1, want); end
        temp1 = 4'b0010;
        ticks(2);
        wait_valve1();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL hot_sprinkler got %h want %h", obs1, want); end
    endtask

    task automatic test_demotion();
        exp_q.push_back(mk(4'b0010, 2'b10, 2'd1, 5'd25, 1'b0, 1'b0));
        exp_q.push_back(mk(4'b0010, 2'b01, 2'd1, 5'd20, 1'b0, 1'b0));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd2, 5'd2, 1'b1, 1'b1));
        ticks(5);
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL demote_pre got %h want %h", obs1, want); end
        level1 = 2'd1;
        step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL demote got %h want %h", obs1, want); end
        level1 = 2'd0;
        step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL demote_empty got %h want %h", obs1, want); end
        level1 = 2'd3; soil1 = 4'hF;
        ticks(2);
    endtask

    task automatic test_button();
        soil1 = 4'b1110; air1 = 4'hF; temp1 = 4'h0;
        exp_q.push_back(mk(4'b0001, 2'b01, 2'd0, 5'd10, 1'b0, 1'b0));
        exp_q.push_back(mk(4'b0001, 2'b01, 2'd0, 5'd10, 1'b0, 1'b0));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd1, 5'd2, 1'b1, 1'b1));
        exp_q.push_back(mk(4'b0001, 2'b01, 2'd0, 5'd1, 1'b0, 1'b0));
        exp_q.push_back(mk(4'h0, 2'b00, 2'd1, 5'd2, 1'b1, 1'b1));
        wait_valve1();
        ticks(10);
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL btn_pre got %h want %h", obs1, want); end
        btn1 = 1'b1;
        step(); step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL btn_latency got %h want %h", obs1, want); end
        step();
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL btn_abort got %h want %h", obs1, want); end
        btn1 = 1'b0;
        ticks(2);
        wait_valve1();
        ticks(19);
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL btn_tick_pre got %h want %h", obs1, want); end
        btn1 = 1'b1;
        step(); step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        want = exp_q.pop_front(); n_cmp++;
        if (obs1 !== want) begin n_fail++; $display("FAIL btn_beats_tick got %h want %h", obs1, want); end
        btn1 = 1'b0; soil1 = 4'hF;
        ticks(2);
    endtask

    task automatic test_round_robin();
        int z;
        int nz;
        soil2 = 3'b000; air2 = 3'b000; temp2 = 3'b000; level2 = 2'd3;
        for (int k = 0; k < 6; k++) zone_q.push_back(k % 3);
        rst2 = 1'b0;
        for (int i = 0; i < 10 && valve2 == 3'b000; i++) step();
        for (int k = 0; k < 6; k++) begin
            z = zone_q.pop_front();
            nz = (z + 1) % 3;
            n_cmp++;
            if ({valve2, zone2, mode2, rem2} !== {3'(1 << z), 2'(z), 2'b10, 2'd3}) begin
                n_fail++;
                $display("FAIL rr_open[%0d] got v=%b z=%0d m=%b r=%0d want zone %0d", k, valve2, zone2, mode2, rem2, z);
            end
            ticks(3);
            n_cmp++;
            if ({valve2, zone2, mode2, rem2, done2, abort2} !== {3'b000, 2'(nz), 2'b00, 2'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL rr_done[%0d] got v=%b z=%0d r=%0d d=%b a=%b want z=%0d done", k, valve2, zone2, rem2, done2, abort2, nz);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_run();
        ticks(1);
        rst2 = 1'b1;
        #1;
        n_cmp++;
        if ({valve2, zone2, mode2, rem2, done2} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b z=%0d m=%b r=%0d d=%b want all zero", valve2, zone2, mode2, rem2, done2);
        end
        step();
    endtask

    task automatic test_empty_tank();
        int opened = 0;
        level2 = 2'd0;
        step();
        rst2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valve2 != 3'b000) opened++;
        end
        n_cmp++;
        if (opened !== 0) begin n_fail++; $display("FAIL empty_never_opens got %0d open cycles want 0", opened); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sprinkler_run();
        test_drip_and_empty();
        test_demotion();
        test_button();
        test_round_robin();
        test_reset_mid_run();
        test_empty_tank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
